regfile_sb: RTL and testbench
=============================

# regfile_sb

Architectural integer register file with an in-flight write scoreboard. It sits between the writeback stage and decode. It accepts the writeback port, which carries data, destination register and a write enable, and serves two combinational read ports to decode. It tracks registers with outstanding writes so decode can stall on RAW/WAW hazards, and it exposes a0–a7 continuously for the ECALL path.

## Interface
Parameters:
- REGBITS, 5, register index width
- LOGSIZE, 64, data width
- NREGS, 32, number of architectural registers
- SP_INIT, 64'h0, reset value of x2 (sp)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- wr_en  in  1  writeback valid
- wr_reg  in  REGBITS  writeback destination
- wr_data  in  LOGSIZE  writeback data
- rs1_addr, rs2_addr  in  REGBITS  decode source indices
- rs1_used, rs2_used  in  1  source actually read by the instruction
- rs1_data, rs2_data  out  LOGSIZE  source values (combinational)
- iss_valid  in  1  decode wants to issue
- iss_rd  in  REGBITS  destination of the issuing instruction
- stall  out  1  hazard; the issue is not accepted this cycle
- flush  in  1  pipeline flush (ECALL/redirect); drops all pending marks
- busy_cnt  out  $clog2(NREGS)+1  number of pending registers (registered)
- ecall_reg_val  out  [7:0] x LOGSIZE  x10..x17, index 0 = a0

## Operation
- Storage: NREGS x LOGSIZE flops and a pending[NREGS] bit vector.
- x0 always reads 0. Writes to x0 are ignored, and x0 is never marked pending.
- Write: if wr_en and wr_reg!=0, the value is committed at posedge. pending[wr_reg] clears at the same posedge.
- Issue accepted = iss_valid && !stall. On acceptance, if iss_rd!=0, pending[iss_rd] is set at posedge.
- stall = iss_valid && ((rs1_used && pend(rs1_addr)) || (rs2_used && pend(rs2_addr)) || pend(iss_rd)).
  - The last term is the WAW check.
  - pend(r) = pending[r] && r!=0, further qualified by the bypass configuration.
- Flush: at posedge, all pending bits and busy_cnt clear.
  - A write in the same cycle still commits its data.
  - An issue in the same cycle is dropped, so nothing is set.
- Simultaneous set and clear of the same register cannot occur, because WAW stall blocks the issue. If it did occur, set wins.
- busy_cnt: +1 on accepted issue with rd!=0, −1 on wr_en with wr_reg pending, net when both occur, 0 on flush.
  - Invariant: busy_cnt == popcount(pending).
  - A write to a non-pending register (for example, post-flush) does not decrement.
- ecall_reg_val[i] = regs[10+i], taken from the array without the bypass.

## Timing
- Reset (rst=0, async): all registers 0 except x2=SP_INIT, pending=0, busy_cnt=0. All outputs follow combinationally; stall=0 while iss_valid=0.
- Read latency: 0 cycles, combinational from the array.
- Write-to-read latency: 1 cycle without bypass; 0 cycles with bypass.
- Issue-to-stall visibility: the pending bit set at edge N affects stall from cycle N+1.
- Release of rst mid-operation: state restarts from reset values. In-flight writes arriving later are committed but do not decrement busy_cnt.

## Configuration
- RF_WB_BYPASS_EN defined:
  - when wr_en && wr_reg==rsX_addr && rsX_addr!=0, rsX_data = wr_data.
  - pend(r) excludes r==wr_reg when wr_en, so a consumer issues in the writeback cycle.
- Not defined:
  - reads return the array value.
  - stall persists through the writeback cycle, and the consumer issues one cycle later.

## Structure
- Package regfile_pkg holds:
  - typedef reg_idx_t (logic [REGBITS-1:0])
  - constants REG_ZERO=0, REG_SP=2, REG_A0=10, NUM_ECALL_ARGS=8
- Sub-module sb_hazard: purely combinational. It takes pending, wr_en/wr_reg, rs/rd indices and used bits, and produces stall. It contains the bypass-qualified pend() logic.

## Test plan
- Reset: assert rst=0 with SP_INIT=64'h8000. Require x2 reads 64'h8000, x5 reads 0, busy_cnt=0.
- RAW: issue rd=5, then a consumer with rs1=5. Require stall=1.
  - After wr_en/wr_reg=5/wr_data=64'hDEAD, the consumer issues in the same cycle (bypass) or the next cycle (no bypass), and rs1_data=64'hDEAD.
- x0: write 64'h1234 to x0 and issue rd=0. Require x0 reads 0, no stall, busy_cnt unchanged.
- Flush: issue rd=3, 7, 9 (busy_cnt=3), then assert flush together with iss_valid rd=11. Require busy_cnt=0, no pending bits, and an rs1=11 read does not stall.
- ECALL view: write x10..x17 = 1..8. Require ecall_reg_val[0]=1 … [7]=8 the following cycle.
- WAW: issue rd=6 and, before its writeback, issue rd=6 again. Require stall=1 until the write to x6, with busy_cnt held at 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared index type and register-name constants for regfile_sb
// Ports: none (package).
package regfile_pkg;

  localparam int RF_REGBITS = 5;

  typedef logic [RF_REGBITS-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO       = '0;
  localparam int       REG_SP         = 2;
  localparam int       REG_A0         = 10;
  localparam int       NUM_ECALL_ARGS = 8;

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - writeback/decode bundle between the pipeline and regfile_sb
// Ports (signals):
//   wr_en/wr_reg/wr_data          writeback port
//   rs1_*/rs2_*                   decode read ports (addr, used, data)
//   iss_valid/iss_rd/stall/flush  issue handshake and pipeline flush
// Modports: master = pipeline side, slave = register file side.
interface regfile_sb_if #(
  parameter int REGBITS = 5,
  parameter int LOGSIZE = 64
);

  logic               wr_en;
  logic [REGBITS-1:0] wr_reg;
  logic [LOGSIZE-1:0] wr_data;

  logic [REGBITS-1:0] rs1_addr;
  logic [REGBITS-1:0] rs2_addr;
  logic               rs1_used;
  logic               rs2_used;
  logic [LOGSIZE-1:0] rs1_data;
  logic [LOGSIZE-1:0] rs2_data;

  logic               iss_valid;
  logic [REGBITS-1:0] iss_rd;
  logic               stall;
  logic               flush;

  modport master (
    output wr_en, wr_reg, wr_data,
    output rs1_addr, rs2_addr, rs1_used, rs2_used,
    output iss_valid, iss_rd, flush,
    input  rs1_data, rs2_data, stall
  );

  modport slave (
    input  wr_en, wr_reg, wr_data,
    input  rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  iss_valid, iss_rd, flush,
    output rs1_data, rs2_data, stall
  );

endinterface

// File: rtl/regfile_sb_hazard.sv
// rtl/regfile_sb_hazard.sv - combinational RAW/WAW hazard detect for the write scoreboard
// Ports:
//   pending_i                      per-register outstanding-write marks
//   wr_en_i/wr_reg_i               writeback in flight this cycle
//   iss_valid_i/iss_rd_i           issuing instruction and its destination
//   rs1_addr_i/rs1_used_i, rs2_*   issuing instruction sources
//   stall_o                        issue must be held this cycle
// Build option: RF_WB_BYPASS_EN lets a register being written back this cycle count as ready.
module sb_hazard
  import regfile_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int NREGS   = 32
) (
  input  logic [NREGS-1:0]   pending_i,
  input  logic               wr_en_i,
  input  logic [REGBITS-1:0] wr_reg_i,
  input  logic               iss_valid_i,
  input  logic [REGBITS-1:0] iss_rd_i,
  input  logic [REGBITS-1:0] rs1_addr_i,
  input  logic               rs1_used_i,
  input  logic [REGBITS-1:0] rs2_addr_i,
  input  logic               rs2_used_i,
  output logic               stall_o
);

  logic pend_rs1;
  logic pend_rs2;
  logic pend_rd;

`ifdef RF_WB_BYPASS_EN
  // A value arriving on the writeback port this cycle is forwarded to the
  // read ports, so its register no longer blocks the consumer.
  function automatic logic pend(input logic [NREGS-1:0] pv, input logic [REGBITS-1:0] r,
                                input logic wen, input logic [REGBITS-1:0] wreg);
    return pv[r] && (r != REG_ZERO) && !(wen && (r == wreg));
  endfunction

  assign pend_rs1 = pend(pending_i, rs1_addr_i, wr_en_i, wr_reg_i);
  assign pend_rs2 = pend(pending_i, rs2_addr_i, wr_en_i, wr_reg_i);
  assign pend_rd  = pend(pending_i, iss_rd_i,   wr_en_i, wr_reg_i);
`else
  function automatic logic pend(input logic [NREGS-1:0] pv, input logic [REGBITS-1:0] r);
    return pv[r] && (r != REG_ZERO);
  endfunction

  assign pend_rs1 = pend(pending_i, rs1_addr_i);
  assign pend_rs2 = pend(pending_i, rs2_addr_i);
  assign pend_rd  = pend(pending_i, iss_rd_i);

  // Writeback timing does not influence hazards without forwarding.
  logic unused_wb;
  assign unused_wb = ^{wr_en_i, wr_reg_i};
`endif

  // The destination term catches WAW: a second writer must wait for the first.
  assign stall_o = iss_valid_i &&
                   ((rs1_used_i && pend_rs1) || (rs2_used_i && pend_rs2) || pend_rd);

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with in-flight write scoreboard
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   rf (slave)       writeback port, two combinational read ports, issue/stall, flush
//   busy_cnt         registered count of registers with an outstanding write
//   ecall_reg_val    a0..a7 straight from the array (index 0 = a0), never forwarded
// Build option: RF_WB_BYPASS_EN forwards wr_data to matching read ports in the writeback cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int                 REGBITS = 5,
  parameter int                 LOGSIZE = 64,
  parameter int                 NREGS   = 32,
  parameter logic [LOGSIZE-1:0] SP_INIT = '0
) (
  input  logic                                    clk,
  input  logic                                    rst,
  regfile_sb_if.slave                             rf,
  output logic [$clog2(NREGS):0]                  busy_cnt,
  output logic [NUM_ECALL_ARGS-1:0][LOGSIZE-1:0]  ecall_reg_val
);

  localparam int CNTW = $clog2(NREGS) + 1;

  logic [LOGSIZE-1:0] regs_q [NREGS];
  logic [NREGS-1:0]   pending_q, pending_d;
  logic [CNTW-1:0]    busy_q, busy_d;

  logic stall;
  logic wr_commit;
  logic wr_clears;
  logic iss_sets;

  sb_hazard #(
    .REGBITS (REGBITS),
    .NREGS   (NREGS)
  ) u_hazard (
    .pending_i   (pending_q),
    .wr_en_i     (rf.wr_en),
    .wr_reg_i    (rf.wr_reg),
    .iss_valid_i (rf.iss_valid),
    .iss_rd_i    (rf.iss_rd),
    .rs1_addr_i  (rf.rs1_addr),
    .rs1_used_i  (rf.rs1_used),
    .rs2_addr_i  (rf.rs2_addr),
    .rs2_used_i  (rf.rs2_used),
    .stall_o     (stall)
  );

  assign rf.stall = stall;

  // x0 is hardwired: never written and never marked.
  assign wr_commit = rf.wr_en && (rf.wr_reg != REG_ZERO);
  // Only a write that retires an outstanding mark reduces the count; stray
  // writes (e.g. after a flush or reset) leave it alone.
  assign wr_clears = wr_commit && pending_q[rf.wr_reg];
  assign iss_sets  = rf.iss_valid && !stall && (rf.iss_rd != REG_ZERO);

  always_comb begin
    pending_d = pending_q;
    busy_d    = busy_q;
    if (rf.flush) begin
      pending_d = '0;
      busy_d    = '0;
    end else begin
      if (wr_commit) pending_d[rf.wr_reg] = 1'b0;
      // Applied after the clear so a same-register set wins.
      if (iss_sets)  pending_d[rf.iss_rd] = 1'b1;
      case ({iss_sets, wr_clears})
        2'b10:   busy_d = busy_q + CNTW'(1);
        2'b01:   busy_d = busy_q - CNTW'(1);
        default: busy_d = busy_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
      pending_q <= '0;
      busy_q    <= '0;
    end else begin
      if (wr_commit) regs_q[rf.wr_reg] <= rf.wr_data;
      pending_q <= pending_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_cnt = busy_q;

  always_comb begin
    rf.rs1_data = (rf.rs1_addr == REG_ZERO) ? '0 : regs_q[rf.rs1_addr];
    rf.rs2_data = (rf.rs2_addr == REG_ZERO) ? '0 : regs_q[rf.rs2_addr];
`ifdef RF_WB_BYPASS_EN
    // wr_commit already excludes x0, so x0 keeps reading zero.
    if (wr_commit && (rf.wr_reg == rf.rs1_addr)) rf.rs1_data = rf.wr_data;
    if (wr_commit && (rf.wr_reg == rf.rs2_addr)) rf.rs2_data = rf.wr_data;
`endif
  end

  for (genvar g = 0; g < NUM_ECALL_ARGS; g++) begin : g_ecall
    assign ecall_reg_val[g] = regs_q[REG_A0 + g];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb (vector table + busy_cnt scoreboard)
module tb_regfile_sb;

  localparam int          REGBITS = 5;
  localparam int          LOGSIZE = 64;
  localparam int          NREGS   = 32;
  localparam logic [63:0] SP_INIT = 64'h8000;
`ifdef RF_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [5:0]      busy_cnt;
  logic [7:0][63:0] ecall_reg_val;

  regfile_sb_if #(.REGBITS(REGBITS), .LOGSIZE(LOGSIZE)) rf ();

  regfile_sb #(
    .REGBITS (REGBITS),
    .LOGSIZE (LOGSIZE),
    .NREGS   (NREGS),
    .SP_INIT (SP_INIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rf            (rf.slave),
    .busy_cnt      (busy_cnt),
    .ecall_reg_val (ecall_reg_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [4:0]  r1;
    logic        u1;
    logic [4:0]  r2;
    logic        u2;
    logic        iv;
    logic [4:0]  rd;
    logic        fl;
    logic        x_stall;
    logic [63:0] x_r1;
    logic [63:0] x_r2;
    logic [5:0]  x_busy;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         checks = 0;
  int         passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                              input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                              input logic u2, input logic iv, input logic [4:0] rd,
                              input logic fl, input logic xs, input logic [63:0] x1,
                              input logic [63:0] x2, input logic [5:0] xb);
    vecs.push_back('{we, wr, wd, r1, u1, r2, u2, iv, rd, fl, xs, x1, x2, xb});
  endfunction

  task automatic drive(input vec_t v);
    rf.wr_en     = v.we;
    rf.wr_reg    = v.wr;
    rf.wr_data   = v.wd;
    rf.rs1_addr  = v.r1;
    rf.rs1_used  = v.u1;
    rf.rs2_addr  = v.r2;
    rf.rs2_used  = v.u2;
    rf.iss_valid = v.iv;
    rf.iss_rd    = v.rd;
    rf.flush     = v.fl;
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive('{1'b0, 5'd0, 64'd0, r1, 1'b0, r2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 64'd0, 6'd0});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //  we wr  wd         r1 u1 r2 u2 iv rd fl | stall     rs1             rs2      busy
    // RAW through writeback
    add(0, 0,  64'h0,     2, 0, 0, 0, 1, 5, 0,   0,        64'h8000,       64'h0,   1);
    add(0, 0,  64'h0,     5, 1, 0, 0, 1, 8, 0,   1,        64'h0,          64'h0,   1);
    add(1, 5,  64'hDEAD,  5, 1, 0, 0, 1, 8, 0,   !BYP,     BYP ? 64'hDEAD : 64'h0, 64'h0, BYP ? 6'd1 : 6'd0);
    add(0, 0,  64'h0,     5, 1, 0, 0, 1, 8, 0,   BYP,      64'hDEAD,       64'h0,   1);
    add(1, 8,  64'h88,    5, 1, 2, 1, 0, 0, 0,   0,        64'hDEAD,       64'h8000, 0);
    // x0 writes/issues are ignored
    add(1, 0,  64'h1234,  0, 1, 0, 1, 1, 0, 0,   0,        64'h0,          64'h0,   0);
    add(0, 0,  64'h0,     0, 1, 8, 1, 1, 0, 0,   0,        64'h0,          64'h88,  0);
    // flush drops marks and the same-cycle issue
    add(0, 0,  64'h0,     2, 0, 0, 0, 1, 3, 0,   0,        64'h8000,       64'h0,   1);
    add(0, 0,  64'h0,     2, 0, 0, 0, 1, 7, 0,   0,        64'h8000,       64'h0,   2);
    add(0, 0,  64'h0,     2, 0, 0, 0, 1, 9, 0,   0,        64'h8000,       64'h0,   3);
    add(0, 0,  64'h0,     0, 0, 0, 0, 1, 11, 1,  0,        64'h0,          64'h0,   0);
    add(0, 0,  64'h0,     11, 1, 3, 1, 1, 12, 0, 0,        64'h0,          64'h0,   1);
    add(1, 7,  64'h77,    9, 1, 0, 0, 0, 0, 0,   0,        64'h0,          64'h0,   1);
    add(1, 12, 64'hC,     7, 1, 0, 0, 0, 0, 0,   0,        64'h77,         64'h0,   0);
    // WAW on x6
    add(0, 0,  64'h0,     0, 0, 0, 0, 1, 6, 0,   0,        64'h0,          64'h0,   1);
    add(0, 0,  64'h0,     0, 0, 0, 0, 1, 6, 0,   1,        64'h0,          64'h0,   1);
    add(0, 0,  64'h0,     0, 0, 0, 0, 1, 6, 0,   1,        64'h0,          64'h0,   1);
    add(1, 6,  64'h66,    0, 0, 0, 0, 1, 6, 0,   !BYP,     64'h0,          64'h0,   BYP ? 6'd1 : 6'd0);
    add(0, 0,  64'h0,     6, 1, 0, 0, 0, 0, 0,   0,        64'h66,         64'h0,   BYP ? 6'd1 : 6'd0);
    add(1, 6,  64'h66,    6, 1, 0, 0, 0, 0, 0,   0,        64'h66,         64'h0,   0);
    // a0..a7 = 1..8
    for (int i = 0; i < 8; i++) begin
      add(1, 5'(10 + i), 64'(i + 1), 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 0);
    end

    // Reset state
    idle(5'd2, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    check("rst_x2", rf.rs1_data, SP_INIT);
    check("rst_x5", rf.rs2_data, 64'h0);
    check("rst_busy", busy_cnt, 6'd0);
    check("rst_stall", rf.stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      check($sformatf("v%0d_stall", k), rf.stall, vecs[k].x_stall);
      check($sformatf("v%0d_rs1", k), rf.rs1_data, vecs[k].x_r1);
      check($sformatf("v%0d_rs2", k), rf.rs2_data, vecs[k].x_r2);
      exp_q.push_back(vecs[k].x_busy);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_busy", k), busy_cnt, exp_q.pop_front());
    end

    // ECALL view the cycle after the last argument write
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ecall_a%0d", i), ecall_reg_val[i], 64'(i + 1));
    end

    // Reset asserted mid-operation, then a late writeback for the lost mark
    @(negedge clk);
    idle(5'd2, 5'd10);
    rf.iss_valid = 1'b1;
    rf.iss_rd    = 5'd4;
    @(posedge clk);
    #1;
    check("mid_busy_before", busy_cnt, 6'd1);
    @(negedge clk);
    idle(5'd2, 5'd10);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy_cnt, 6'd0);
    check("mid_rst_x2", rf.rs1_data, SP_INIT);
    check("mid_rst_a0", ecall_reg_val[0], 64'h0);
    @(negedge clk);
    rst = 1'b1;
    rf.wr_en   = 1'b1;
    rf.wr_reg  = 5'd4;
    rf.wr_data = 64'h44;
    @(posedge clk);
    #1;
    check("late_wr_busy", busy_cnt, 6'd0);
    @(negedge clk);
    idle(5'd4, 5'd0);
    rf.iss_valid = 1'b1;
    rf.iss_rd    = 5'd4;
    #1;
    check("late_wr_data", rf.rs1_data, 64'h44);
    check("late_wr_nostall", rf.stall, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
